reg_port_sequencer: RTL and testbench
=====================================

// Module: reg_port_sequencer
// PURPOSE
//  Registered successor to the combinational register-address/write-data select stage. Each cycle it:
//  - selects the regfile read/write addresses (syscall/link overrides) and holds them in an output stage with a valid/ready handshake;
//  - tracks in-flight writes in a WB_DEPTH-deep scoreboard and stalls on RAW hazards;
//  - drives the regfile write port (RF_WE/RF_WAdr/RDin) from the scoreboard tail.
//  Sits between decode and the regfile.
// PARAMETERS
//  DATA_W      32  regfile data width
//  ADDR_W      5   register address width
//  WB_DEPTH    3   cycles from issue to regfile write (>=1)
//  SYS_NUM_REG 2   read port 1 address forced on Syscall ($v0)
//  SYS_ARG_REG 4   read port 2 address forced on Syscall ($a0)
//  LINK_REG    31  write address forced on JAL ($ra)
// PORTS
//  CLK            in  1       clock, all state on rising edge
//  RST            in  1       synchronous reset, active-high
//  In_Valid       in  1       decode presents an instruction
//  In_Ready       out 1       instruction accepted this cycle when In_Valid&In_Ready
//  JAL            in  1       link write, forces WAdr=LINK_REG and write enable
//  RegDst         in  1       1: write addr from L_11_15, 0: from L_16_20
//  Syscall        in  1       force read addresses SYS_NUM_REG/SYS_ARG_REG
//  RegWrite       in  1       instruction writes the regfile
//  Flush          in  1       kill the held (unissued) instruction
//  L_21_25        in  ADDR_W  rs field
//  L_16_20        in  ADDR_W  rt field
//  L_11_15        in  ADDR_W  rd field
//  L_6_10         in  ADDR_W  shamt field
//  Out_Valid      out 1       output stage holds an instruction
//  Out_Ready      in  1       downstream consumes it (issue = Out_Valid&Out_Ready&~Flush)
//  R1Adr          out ADDR_W  registered read address 1
//  R2Adr          out ADDR_W  registered read address 2
//  WAdr           out ADDR_W  registered write address
//  Shamt          out ADDR_W  registered shamt
//  Out_RegWrite   out 1       registered effective write enable
//  Out_JAL        out 1       registered JAL flag
//  WriteBack_Data in  DATA_W  write-back data aligned with scoreboard tail
//  PC_plus_four   in  DATA_W  link value aligned with scoreboard tail
//  RF_WE          out 1       regfile write enable
//  RF_WAdr        out ADDR_W  regfile write address
//  RDin           out DATA_W  regfile write data
//  Stall_Count    out 16      saturating count of hazard-stall cycles
// BEHAVIOUR
//  Address select (combinational, on inputs):
//   - r1 = Syscall ? SYS_NUM_REG : L_21_25
//   - r2 = Syscall ? SYS_ARG_REG : L_16_20
//   - w  = JAL ? LINK_REG : (RegDst ? L_11_15 : L_16_20)
//   - we = (RegWrite|JAL) & (w!=0)
//  Hazard: hz = In_Valid & ((r1!=0 & hit(r1)) | (r2!=0 & hit(r2))).
//   - hit(a) is true if a equals WAdr of the output stage (Out_Valid&Out_RegWrite), or of any valid scoreboard entry with we, tail included.
//   - No bypass; reads of register 0 never stall.
//  In_Ready = ~RST & ~Flush & ~hz & (~Out_Valid | Out_Ready). Combinational from In_Valid and the fields; no combinational path from In_Ready back to any input.
//  Output stage, priority order:
//   1. RST: Out_Valid=0, all registered outputs 0.
//   2. Flush: Out_Valid<=0.
//   3. Accept: load r1, r2, w, L_6_10, we, JAL; Out_Valid<=1.
//   4. Issue without accept: Out_Valid<=0.
//   5. Otherwise: hold.
//   - Latency: accept in cycle N gives Out_Valid in N+1.
//   - Back-to-back accept/issue at one per cycle when hazard-free.
//  Scoreboard: entries 0..WB_DEPTH-1 of {valid, we, waddr, jal}; shifts every cycle.
//   - entry0 <= issue ? {1,Out_RegWrite,WAdr,Out_JAL} : 0; entry[k] <= entry[k-1].
//   - Flush does not clear the scoreboard (issued instructions are committed).
//   - RST clears all entries.
//  Write port (combinational from tail, entry WB_DEPTH-1):
//   - RF_WE = valid&we; RF_WAdr = waddr (0 when RF_WE=0).
//   - RDin = jal ? PC_plus_four : WriteBack_Data.
//   - Issue at edge ending cycle M gives RF_WE during cycle M+WB_DEPTH.
//  Stall_Count: +1 on each cycle with In_Valid&hz&~Flush; saturates at 16'hFFFF; back-pressure cycles are not counted; RST -> 0.
//  Reset mid-operation: the held instruction and all pending writes are discarded. The first cycle after RST deasserts shows RF_WE=0, Out_Valid=0, In_Ready=1 when hazard-free.
// TESTING (WB_DEPTH=3, Out_Ready=1 unless stated)
//  1. add $3,$1,$2 (RegDst=1,RegWrite=1) accepted cycle 0:
//     - cycle 1: R1Adr=1, R2Adr=2, WAdr=3, Out_Valid=1
//     - cycle 4: RF_WE=1, RF_WAdr=3, RDin=WriteBack_Data
//  2. Syscall=1, L_21_25=7, L_16_20=9 -> R1Adr=2, R2Adr=4 next cycle.
//  3. JAL=1, PC_plus_four=32'h00400008:
//     - WAdr=31
//     - 3 cycles after issue: RF_WAdr=31, RDin=32'h00400008
//  4. Write $5 accepted cycle 0, reader of $5 presented from cycle 1:
//     - In_Ready=0 cycles 1-4; accept cycle 5; Stall_Count=4
//     - same sequence with $0: no stall
//  5. Out_Valid=1, Out_Ready=0, Flush=1 one cycle -> Out_Valid=0 next cycle, no scoreboard entry, RF_WE never asserts for it.
//  6. RST for 1 cycle with 2 writes pending -> RF_WE=0 thereafter, Stall_Count=0, Out_Valid=0.

Source files
------------

// File: rtl/reg_port_sequencer.sv
// Registered regfile address/write-data sequencer.
// Output stage with handshake, WB scoreboard, RAW stall.
module reg_port_sequencer #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int WB_DEPTH    = 3,
  parameter int SYS_NUM_REG = 2,
  parameter int SYS_ARG_REG = 4,
  parameter int LINK_REG    = 31
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic              JAL,
  input  logic              RegDst,
  input  logic              Syscall,
  input  logic              RegWrite,
  input  logic              Flush,
  input  logic [ADDR_W-1:0] L_21_25,
  input  logic [ADDR_W-1:0] L_16_20,
  input  logic [ADDR_W-1:0] L_11_15,
  input  logic [ADDR_W-1:0] L_6_10,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [ADDR_W-1:0] R1Adr,
  output logic [ADDR_W-1:0] R2Adr,
  output logic [ADDR_W-1:0] WAdr,
  output logic [ADDR_W-1:0] Shamt,
  output logic              Out_RegWrite,
  output logic              Out_JAL,
  input  logic [DATA_W-1:0] WriteBack_Data,
  input  logic [DATA_W-1:0] PC_plus_four,
  output logic              RF_WE,
  output logic [ADDR_W-1:0] RF_WAdr,
  output logic [DATA_W-1:0] RDin,
  output logic [15:0]       Stall_Count
);

  localparam int T = WB_DEPTH - 1;
  localparam logic [ADDR_W-1:0] LP_NUM  = ADDR_W'(SYS_NUM_REG);
  localparam logic [ADDR_W-1:0] LP_ARG  = ADDR_W'(SYS_ARG_REG);
  localparam logic [ADDR_W-1:0] LP_LINK = ADDR_W'(LINK_REG);

  logic              r_valid;
  logic [ADDR_W-1:0] r_r1, r_r2, r_w, r_sh;
  logic              r_we, r_jal;
  logic [WB_DEPTH-1:0] r_sb_v, r_sb_we, r_sb_jal;
  logic [ADDR_W-1:0] r_sb_wa [WB_DEPTH];
  logic [15:0]       r_stall;

  logic [ADDR_W-1:0] w_r1, w_r2, w_w;
  logic              w_we, w_hit1, w_hit2, w_hz;
  logic              w_ready, w_accept, w_issue;

  assign w_r1 = Syscall ? LP_NUM : L_21_25;
  assign w_r2 = Syscall ? LP_ARG : L_16_20;
  assign w_w  = JAL ? LP_LINK : (RegDst ? L_11_15 : L_16_20);
  assign w_we = (RegWrite | JAL) & (w_w != '0);

  // Match read addresses against every pending write (stage + scoreboard)
  always_comb begin
    w_hit1 = r_valid & r_we & (r_w == w_r1);
    w_hit2 = r_valid & r_we & (r_w == w_r2);
    for (int k = 0; k < WB_DEPTH; k++) begin
      w_hit1 = w_hit1 | (r_sb_v[k] & r_sb_we[k] & (r_sb_wa[k] == w_r1));
      w_hit2 = w_hit2 | (r_sb_v[k] & r_sb_we[k] & (r_sb_wa[k] == w_r2));
    end
  end

  assign w_hz = In_Valid & (((w_r1 != '0) & w_hit1) |
                            ((w_r2 != '0) & w_hit2));
  assign w_ready  = ~RST & ~Flush & ~w_hz & (~r_valid | Out_Ready);
  assign w_accept = In_Valid & w_ready;
  assign w_issue  = r_valid & Out_Ready & ~Flush;

  // Output stage: reset, flush, accept, drain, hold
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= 1'b0;
      r_r1    <= '0;
      r_r2    <= '0;
      r_w     <= '0;
      r_sh    <= '0;
      r_we    <= 1'b0;
      r_jal   <= 1'b0;
    end else if (Flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_r1    <= w_r1;
      r_r2    <= w_r2;
      r_w     <= w_w;
      r_sh    <= L_6_10;
      r_we    <= w_we;
      r_jal   <= JAL;
    end else if (w_issue) begin
      r_valid <= 1'b0;
    end
  end

  // Scoreboard shifts every cycle; issued writes survive Flush
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sb_v   <= '0;
      r_sb_we  <= '0;
      r_sb_jal <= '0;
      for (int k = 0; k < WB_DEPTH; k++) r_sb_wa[k] <= '0;
    end else begin
      r_sb_v[0]   <= w_issue;
      r_sb_we[0]  <= w_issue & r_we;
      r_sb_jal[0] <= w_issue & r_jal;
      r_sb_wa[0]  <= w_issue ? r_w : '0;
      for (int k = 1; k < WB_DEPTH; k++) begin
        r_sb_v[k]   <= r_sb_v[k-1];
        r_sb_we[k]  <= r_sb_we[k-1];
        r_sb_jal[k] <= r_sb_jal[k-1];
        r_sb_wa[k]  <= r_sb_wa[k-1];
      end
    end
  end

  // Saturating count of hazard stalls (back-pressure excluded)
  always_ff @(posedge CLK) begin
    if (RST)
      r_stall <= '0;
    else if (w_hz & ~Flush & (r_stall != 16'hFFFF))
      r_stall <= r_stall + 16'd1;
  end

  assign In_Ready     = w_ready;
  assign Out_Valid    = r_valid;
  assign R1Adr        = r_r1;
  assign R2Adr        = r_r2;
  assign WAdr         = r_w;
  assign Shamt        = r_sh;
  assign Out_RegWrite = r_we;
  assign Out_JAL      = r_jal;
  assign Stall_Count  = r_stall;

  assign RF_WE   = r_sb_v[T] & r_sb_we[T];
  assign RF_WAdr = RF_WE ? r_sb_wa[T] : '0;
  assign RDin    = r_sb_jal[T] ? PC_plus_four : WriteBack_Data;

endmodule

// File: tb/tb_reg_port_sequencer.sv
// Directed bench for reg_port_sequencer.
// Expected regfile writes are queued at accept time.
module tb_reg_port_sequencer;

  localparam logic [31:0] PC4 = 32'h00400008;

  logic        CLK = 1'b0;
  logic        RST, In_Valid, In_Ready, JAL, RegDst, Syscall;
  logic        RegWrite, Flush, Out_Valid, Out_Ready;
  logic [4:0]  L_21_25, L_16_20, L_11_15, L_6_10;
  logic [4:0]  R1Adr, R2Adr, WAdr, Shamt, RF_WAdr;
  logic        Out_RegWrite, Out_JAL, RF_WE;
  logic [31:0] WriteBack_Data, PC_plus_four, RDin;
  logic [15:0] Stall_Count;

  always #5 CLK = ~CLK;

  reg_port_sequencer dut (
    .CLK(CLK), .RST(RST), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .JAL(JAL), .RegDst(RegDst), .Syscall(Syscall),
    .RegWrite(RegWrite), .Flush(Flush),
    .L_21_25(L_21_25), .L_16_20(L_16_20), .L_11_15(L_11_15),
    .L_6_10(L_6_10), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .R1Adr(R1Adr), .R2Adr(R2Adr), .WAdr(WAdr), .Shamt(Shamt),
    .Out_RegWrite(Out_RegWrite), .Out_JAL(Out_JAL),
    .WriteBack_Data(WriteBack_Data), .PC_plus_four(PC_plus_four),
    .RF_WE(RF_WE), .RF_WAdr(RF_WAdr), .RDin(RDin),
    .Stall_Count(Stall_Count)
  );

  typedef struct {
    int         cyc;
    logic [4:0] a;
    logic       jal;
  } exp_t;

  exp_t   q[$];
  int     nchk = 0;
  int     nerr = 0;
  int     cyc  = 0;
  int     exp_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle_in;
    In_Valid = 0; JAL = 0; RegDst = 0; Syscall = 0;
    RegWrite = 0; Flush = 0;
    L_21_25 = 0; L_16_20 = 0; L_11_15 = 0; L_6_10 = 0;
  endtask

  task automatic push(input int c, input logic [4:0] a,
                      input logic j);
    exp_t e;
    e.cyc = c; e.a = a; e.jal = j;
    q.push_back(e);
  endtask

  task automatic next;
    exp_t e;
    #1;
    if (RF_WE === 1'b1) begin
      if (q.size() == 0) begin
        chk("wp_unexpected", 32'(RF_WAdr), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("wp_cycle", 32'(cyc), 32'(e.cyc));
        chk("wp_addr", 32'(RF_WAdr), 32'(e.a));
        chk("wp_data", RDin,
            e.jal ? PC4 : (32'hD000_0000 | 32'(e.cyc)));
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    WriteBack_Data = 32'hD000_0000 | 32'(cyc);
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    idle_in();
    Out_Ready = 1;
    PC_plus_four = PC4;
    WriteBack_Data = 0;
    RST = 1;
    next(); next();
    RST = 0;
    cyc = 0;
    WriteBack_Data = 32'hD000_0000;
    settle();
    chk("rst_out_valid", 32'(Out_Valid), 0);
    chk("rst_rf_we", 32'(RF_WE), 0);
    chk("rst_in_ready", 32'(In_Ready), 1);
    chk("rst_stall", 32'(Stall_Count), 0);
    chk("rst_wadr", 32'(WAdr), 0);

    // add $3,$1,$2
    In_Valid = 1; RegDst = 1; RegWrite = 1;
    L_21_25 = 1; L_16_20 = 2; L_11_15 = 3; L_6_10 = 5'd9;
    settle();
    chk("add_in_ready", 32'(In_Ready), 1);
    push(cyc + 4, 5'd3, 1'b0);
    next();
    idle_in();
    settle();
    chk("add_r1", 32'(R1Adr), 1);
    chk("add_r2", 32'(R2Adr), 2);
    chk("add_w", 32'(WAdr), 3);
    chk("add_sh", 32'(Shamt), 9);
    chk("add_we", 32'(Out_RegWrite), 1);
    chk("add_valid", 32'(Out_Valid), 1);

    // syscall read override
    In_Valid = 1; Syscall = 1; L_21_25 = 7; L_16_20 = 9;
    settle();
    chk("sys_in_ready", 32'(In_Ready), 1);
    next();
    idle_in();
    settle();
    chk("sys_r1", 32'(R1Adr), 2);
    chk("sys_r2", 32'(R2Adr), 4);
    chk("sys_we", 32'(Out_RegWrite), 0);

    // JAL link write
    In_Valid = 1; JAL = 1;
    settle();
    chk("jal_in_ready", 32'(In_Ready), 1);
    push(cyc + 4, 5'd31, 1'b1);
    next();
    idle_in();
    settle();
    chk("jal_w", 32'(WAdr), 31);
    chk("jal_flag", 32'(Out_JAL), 1);
    chk("jal_we", 32'(Out_RegWrite), 1);
    repeat (5) next();
    chk("drain1_q", 32'(q.size()), 0);

    // RAW on $5 through r1
    In_Valid = 1; RegWrite = 1; RegDst = 1; L_11_15 = 5;
    settle();
    chk("w5_in_ready", 32'(In_Ready), 1);
    push(cyc + 4, 5'd5, 1'b0);
    next();
    idle_in();
    In_Valid = 1; L_21_25 = 5;
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk($sformatf("raw5_stall%0d", i), 32'(In_Ready), 0);
      exp_stall++;
      next();
    end
    settle();
    chk("raw5_accept", 32'(In_Ready), 1);
    next();
    idle_in();
    settle();
    chk("raw5_count", 32'(Stall_Count), 32'(exp_stall));
    chk("raw5_r1", 32'(R1Adr), 5);

    // RAW on $6 through r2
    In_Valid = 1; RegWrite = 1; L_16_20 = 6;
    settle();
    chk("w6_in_ready", 32'(In_Ready), 1);
    push(cyc + 4, 5'd6, 1'b0);
    next();
    idle_in();
    In_Valid = 1; L_16_20 = 6;
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk($sformatf("raw6_stall%0d", i), 32'(In_Ready), 0);
      exp_stall++;
      next();
    end
    settle();
    chk("raw6_accept", 32'(In_Ready), 1);
    next();
    idle_in();

    // write to $0 then read $0: never stalls
    In_Valid = 1; RegWrite = 1; RegDst = 1; L_11_15 = 0;
    next();
    idle_in();
    In_Valid = 1; L_21_25 = 0; L_16_20 = 0;
    settle();
    chk("r0_in_ready", 32'(In_Ready), 1);
    next();
    idle_in();
    settle();
    chk("r0_count", 32'(Stall_Count), 32'(exp_stall));
    repeat (5) next();
    chk("drain2_q", 32'(q.size()), 0);

    // back-pressure then flush of held write $7
    In_Valid = 1; RegWrite = 1; RegDst = 1; L_11_15 = 7;
    next();
    idle_in();
    Out_Ready = 0;
    In_Valid = 1; L_21_25 = 1;
    settle();
    chk("bp_in_ready", 32'(In_Ready), 0);
    next();
    idle_in();
    settle();
    chk("bp_hold_valid", 32'(Out_Valid), 1);
    chk("bp_hold_w", 32'(WAdr), 7);
    Flush = 1;
    settle();
    chk("fl_in_ready", 32'(In_Ready), 0);
    next();
    Flush = 0; Out_Ready = 1;
    settle();
    chk("fl_valid", 32'(Out_Valid), 0);
    chk("fl_count", 32'(Stall_Count), 32'(exp_stall));
    In_Valid = 1; L_21_25 = 7;
    settle();
    chk("fl_no_hazard", 32'(In_Ready), 1);
    next();
    idle_in();
    repeat (5) next();

    // reset with two writes pending
    In_Valid = 1; RegWrite = 1; RegDst = 1; L_11_15 = 8;
    next();
    L_11_15 = 9;
    next();
    idle_in();
    RST = 1;
    settle();
    chk("rst2_in_ready", 32'(In_Ready), 0);
    next();
    RST = 0;
    exp_stall = 0;
    settle();
    chk("rst2_valid", 32'(Out_Valid), 0);
    chk("rst2_rf_we", 32'(RF_WE), 0);
    chk("rst2_stall", 32'(Stall_Count), 0);
    chk("rst2_in_ready", 32'(In_Ready), 1);
    repeat (6) next();
    chk("final_q", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
